// File: rtl/miriscv_dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_dmem_arbiter_if
// Brief    : Two-master data-memory bus plus RAM-side port for the arbiter.
// Revision : 1.0
// ============================================================================
interface miriscv_dmem_arbiter_if;
    logic        m0_req_i;
    logic        m0_we_i;
    logic [3:0]  m0_be_i;
    logic [31:0] m0_addr_i;
    logic [31:0] m0_wdata_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;
    logic        m0_err_o;

    logic        m1_req_i;
    logic        m1_we_i;
    logic [3:0]  m1_be_i;
    logic [31:0] m1_addr_i;
    logic [31:0] m1_wdata_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;
    logic        m1_err_o;

    logic        ram_req_o;
    logic        ram_we_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i;

    logic [15:0] conflict_cnt_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        input  m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        output ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i,
        output conflict_cnt_o
    );

    modport master (
        output m0_req_i, m0_we_i, m0_be_i, m0_addr_i, m0_wdata_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o, m0_err_o,
        output m1_req_i, m1_we_i, m1_be_i, m1_addr_i, m1_wdata_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o, m1_err_o,
        input  ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i,
        input  conflict_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/miriscv_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : miriscv_dmem_arbiter
// Brief    : Round-robin two-master arbiter onto a single-port data RAM with
//            one-cycle registered responses and a saturating conflict counter.
// Revision : 1.0
// ============================================================================
module miriscv_dmem_arbiter #(
    parameter int RAM_SIZE = 256
) (
    input  wire logic              clk_i,
    input  wire logic              rst_i,
    miriscv_dmem_arbiter_if.slave  bus
);

    localparam logic [31:0] c_RAM_SIZE = 32'(RAM_SIZE);

    logic        r_last_grant;   // 1: master 1 granted most recently
    logic [15:0] r_conflict_cnt;
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic        r_rsp_we;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_any_gnt;
    logic        w_both_req;
    logic        w_in_range0;
    logic        w_in_range1;
    logic        w_sel_in_range;
    logic        w_sel_we;
    logic        w_rsp0;
    logic        w_rsp1;
    logic        w_rsp_data_ok;

    assign w_both_req  = bus.m0_req_i & bus.m1_req_i;
    assign w_in_range0 = bus.m0_addr_i < c_RAM_SIZE;
    assign w_in_range1 = bus.m1_addr_i < c_RAM_SIZE;

    // On conflict the master that did not win last time gets the slot.
    assign w_gnt0    = ~rst_i & bus.m0_req_i & (~bus.m1_req_i |  r_last_grant);
    assign w_gnt1    = ~rst_i & bus.m1_req_i & (~bus.m0_req_i | ~r_last_grant);
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign w_sel_in_range = (w_gnt0 & w_in_range0) | (w_gnt1 & w_in_range1);
    assign w_sel_we       = (w_gnt0 & bus.m0_we_i) | (w_gnt1 & bus.m1_we_i);

    assign bus.m0_gnt_o    = w_gnt0;
    assign bus.m1_gnt_o    = w_gnt1;
    assign bus.ram_req_o   = w_sel_in_range;
    assign bus.ram_we_o    = w_sel_we;
    assign bus.ram_be_o    = w_gnt0 ? bus.m0_be_i    : (w_gnt1 ? bus.m1_be_i    : 4'h0);
    assign bus.ram_addr_o  = w_gnt0 ? bus.m0_addr_i  : (w_gnt1 ? bus.m1_addr_i  : 32'h0);
    assign bus.ram_wdata_o = w_gnt0 ? bus.m0_wdata_i : (w_gnt1 ? bus.m1_wdata_i : 32'h0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant   <= 1'b1;
            r_conflict_cnt <= 16'h0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= 1'b0;
            r_rsp_we       <= 1'b0;
            r_rsp_err      <= 1'b0;
            r_rsp_rdata    <= 32'h0;
        end else begin
            if (w_gnt0) begin
                r_last_grant <= 1'b0;
            end else if (w_gnt1) begin
                r_last_grant <= 1'b1;
            end
            if (w_both_req && (r_conflict_cnt != 16'hFFFF)) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
            r_rsp_valid <= w_any_gnt;
            r_rsp_id    <= w_gnt1;
            r_rsp_we    <= w_sel_we;
            r_rsp_err   <= w_any_gnt & ~w_sel_in_range;
            r_rsp_rdata <= bus.ram_rdata_i;
        end
    end

    // Captured RAM data is only meaningful for an in-range load.
    assign w_rsp0        = ~rst_i & r_rsp_valid & ~r_rsp_id;
    assign w_rsp1        = ~rst_i & r_rsp_valid &  r_rsp_id;
    assign w_rsp_data_ok = ~r_rsp_we & ~r_rsp_err;

    assign bus.m0_rvalid_o = w_rsp0;
    assign bus.m0_err_o    = w_rsp0 & r_rsp_err;
    assign bus.m0_rdata_o  = (w_rsp0 & w_rsp_data_ok) ? r_rsp_rdata : 32'h0;
    assign bus.m1_rvalid_o = w_rsp1;
    assign bus.m1_err_o    = w_rsp1 & r_rsp_err;
    assign bus.m1_rdata_o  = (w_rsp1 & w_rsp_data_ok) ? r_rsp_rdata : 32'h0;

    assign bus.conflict_cnt_o = rst_i ? 16'h0 : r_conflict_cnt;

endmodule
`default_nettype wire

// File: doc/miriscv_dmem_arbiter.md
MIRISCV_DMEM_ARBITER -- requirements
Module: miriscv_dmem_arbiter

Interface
REQ-001 The block SHALL expose parameter RAM_SIZE, default 256, the data RAM size in bytes; legal addresses are 0..RAM_SIZE-1.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The block SHALL expose these ports (name, direction, width, meaning):
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous active-high reset
- m0_req_i  in  1  master 0 (core LSU) request
- m0_we_i  in  1  1=store, 0=load
- m0_be_i  in  4  byte enables
- m0_addr_i  in  32  byte address
- m0_wdata_i  in  32  store data
- m0_gnt_o  out  1  request accepted this cycle
- m0_rvalid_o  out  1  response valid
- m0_rdata_o  out  32  load data
- m0_err_o  out  1  out-of-range access, qualified by rvalid
- m1_* : same nine signals for master 1 (DMA/debug)
- ram_req_o  out  1  RAM data request
- ram_we_o  out  1  RAM write enable
- ram_be_o  out  4  RAM byte enables
- ram_addr_o  out  32  RAM address
- ram_wdata_o  out  32  RAM write data
- ram_rdata_i  in  32  RAM read data, updated on falling edge of request cycle
- conflict_cnt_o  out  16  count of cycles with both masters requesting

Function
REQ-004 mX_gnt_o SHALL be combinational: at most one master is granted per cycle, and a grant is always given when any req is high and rst_i is low.
REQ-005 Single requester: that master SHALL be granted the same cycle.
REQ-006 Both requesting: the master not granted most recently SHALL win (round-robin); last_grant updates only on a grant.
REQ-007 RAM-side signals SHALL be a combinational mux of the granted master's we/be/addr/wdata; ram_req_o=1 only for a granted in-range access; when no master is granted, ram_* outputs SHALL be 0.
REQ-008 In range means addr < RAM_SIZE; out-of-range accesses SHALL be granted with ram_req_o=0.
REQ-009 Response latency SHALL be exactly 1 cycle: a grant in cycle N gives mX_rvalid_o=1 for one cycle in N+1, to the granted master only.
REQ-010 Response capture:
- the block SHALL register ram_rdata_i at the rising edge ending cycle N, together with granted id, we and error flag;
- mX_rdata_o is driven from that register;
- back-to-back grants SHALL NOT corrupt an earlier response.
REQ-011 In-range load SHALL return rdata=RAM word, err=0; store SHALL return rvalid with rdata=0, err=0; out-of-range SHALL return rdata=0, err=1.
REQ-012 Throughput SHALL be one access per cycle; grant in N+1 is independent of the response in N+1.
REQ-013 Non-granted master outputs: rvalid=0, err=0, rdata SHALL be 32'h0.
REQ-014 conflict_cnt_o SHALL increment by 1 each cycle with m0_req_i and m1_req_i both high, and SHALL saturate at 16'hFFFF.
REQ-015 Masters hold req and payload stable until gnt; the block SHALL NOT buffer ungranted requests.

Reset
REQ-016 While rst_i=1: all gnt, rvalid, err and ram_req_o SHALL be 0, and rdata and ram_* buses SHALL be 0.
REQ-017 At reset exit: last_grant=1 (m0 wins first conflict), conflict_cnt_o=0, no pending response.
REQ-018 Reset asserted in the cycle after a grant SHALL drop the pending response (no rvalid); RAM contents are untouched by the arbiter.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- m0 load addr 0x10 (RAM word 0xDEADBEEF) -> m0_gnt same cycle, ram_req_o=1, next cycle m0_rvalid=1, rdata=0xDEADBEEF, err=0.
- m0 and m1 request continuously for 4 cycles after reset -> grants m0,m1,m0,m1; conflict_cnt_o=4.
- m1 store be=4'b0011 wdata 0x12345678 addr 0x20, then m1 load 0x20 (prior word 0) back-to-back -> ram_we_o/ram_be_o pass through; store rvalid rdata=0; load rdata=0x00005678.
- m0 load addr 0x100 with RAM_SIZE=256 -> gnt, ram_req_o=0, next cycle rvalid=1, err=1, rdata=0.
- Grant m0 load, then rst_i high the next cycle -> m0_rvalid stays 0, conflict_cnt_o=0; first post-reset conflict grants m0.
- Force conflict counter to 16'hFFFF, hold both requests -> value stays 16'hFFFF.
